// File: rtl/bam_seq_mult.sv
// -----------------------------------------------------------------------------
// bam_seq_mult
//
// Iterative unsigned broken-array multiplier (BAM) with run-time approximation
// control. The result is the sum of the retained partial products of a * b,
// where partial product a[i] & b[j] (weight i+j) is kept only when
//   j >= cfg_h   (horizontal break: whole low rows of b are dropped), and
//   i + j >= cfg_v (vertical break: low-weight columns are dropped).
//
// One partial-product row is accumulated per clock. Broken rows below cfg_h
// are skipped entirely by starting the row counter at cfg_h, so a larger
// horizontal break gives a shorter latency: out_valid rises max(N - cfg_h, 0)
// rising edges after the accepting edge.
//
// Handshakes (both sides): a transfer happens on a rising edge where valid and
// ready are both high. A producer holding valid must keep its data stable
// until the transfer; ready never depends combinationally on the matching
// valid (in_ready and out_valid are pure decodes of the state register).
//
// Parameters
//   N   operand width (N >= 2); result is 2N bits
//   HW  width of cfg_h
//   VW  width of cfg_v
//
// Ports
//   clk        clock, rising-edge active
//   rst        asynchronous, active-high reset
//   in_valid   operand/config beat valid
//   in_ready   block can accept a beat (state IDLE)
//   a, b       unsigned multiplicand / multiplier
//   cfg_h      horizontal break: rows j < cfg_h omitted
//   cfg_v      vertical break: weights i+j < cfg_v omitted
//   out_valid  result valid (state DONE)
//   out_ready  consumer accepts result
//   result     approximate product, held after the output handshake
//   busy       high in CALC or DONE
//   dbg_state  current FSM state (0 IDLE, 1 CALC, 2 DONE)
// -----------------------------------------------------------------------------
module bam_seq_mult #(
    parameter int N  = 8,
    parameter int HW = $clog2(N + 1),
    parameter int VW = $clog2(2 * N + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    input  logic [HW-1:0]    cfg_h,
    input  logic [VW-1:0]    cfg_v,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   result,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Index of the top partial-product row; a row counter starting above it
    // means every row is broken and the product is zero.
    localparam logic [HW-1:0] LAST_ROW = HW'(N - 1);

    // -------------------------------------------------------------------------
    // State and latched operands
    // -------------------------------------------------------------------------
    state_t           r_state;
    logic [N-1:0]     r_a;
    logic [N-1:0]     r_b;
    logic [VW-1:0]    r_v;
    logic [HW-1:0]    r_row;
    logic [2*N-1:0]   r_acc;
    logic [2*N-1:0]   r_result;

    // -------------------------------------------------------------------------
    // Row datapath
    // -------------------------------------------------------------------------
    logic             w_bit_b;      // b[current row]
    logic [N-1:0]     w_mask;       // per-column keep mask for current row
    logic [2*N-1:0]   w_pp;         // shifted, masked partial-product row
    logic [2*N-1:0]   w_acc_next;   // full-width accumulate, no carry dropped
    logic             w_last;       // current row is the top row

    always_comb begin
        // Select b[r_row] with a compare loop so the row counter (which can
        // legally hold N after acceptance) never indexes past the vector.
        w_bit_b = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (r_row == HW'(j)) begin
                w_bit_b = r_b[j];
            end
        end

        // Column i survives when the row bit is set and its weight i + row
        // reaches the vertical break. i + row <= 2N - 2 always fits in VW bits.
        w_mask = '0;
        for (int i = 0; i < N; i++) begin
            w_mask[i] = w_bit_b && ((VW'(i) + VW'(r_row)) >= r_v);
        end

        w_pp       = {{N{1'b0}}, (r_a & w_mask)} << r_row;
        w_acc_next = r_acc + w_pp;
        w_last     = (r_row == LAST_ROW);
    end

    // -------------------------------------------------------------------------
    // Control FSM and registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_v      <= '0;
            r_row    <= '0;
            r_acc    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // in_ready is high exactly in IDLE, so in_valid alone
                    // completes the input handshake here.
                    if (in_valid) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_v   <= cfg_v;
                        r_row <= cfg_h;
                        r_acc <= '0;
                        if (cfg_h > LAST_ROW) begin
                            // Every row is broken: answer immediately.
                            r_result <= '0;
                            r_state  <= S_DONE;
                        end else begin
                            r_state  <= S_CALC;
                        end
                    end
                end

                S_CALC: begin
                    // No early exit on the vertical break: rows that are fully
                    // masked still take their cycle, keeping latency a function
                    // of cfg_h only.
                    r_acc <= w_acc_next;
                    if (w_last) begin
                        r_result <= w_acc_next;
                        r_state  <= S_DONE;
                    end else begin
                        r_row <= r_row + HW'(1);
                    end
                end

                S_DONE: begin
                    // result is held until the consumer takes it; it keeps
                    // its value after returning to IDLE.
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: decodes of registered state only
    // -------------------------------------------------------------------------
    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = !in_ready;
    assign result    = r_result;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_bam_seq_mult.sv
// -----------------------------------------------------------------------------
// Bench for bam_seq_mult. Two instances (N=8 and N=12) share the clock and
// have separate resets. Directed table vectors and hand sequences run on the
// N=8 instance; random sweeps with output stalls run on both, scored against
// a partial-product reference model through expected-value queues.
// -----------------------------------------------------------------------------
module tb_bam_seq_mult;

    // ---------------------------------------------------------------------
    // Clock / reset
    // ---------------------------------------------------------------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst8  = 1'b0;
    logic rst12 = 1'b0;

    // ---------------------------------------------------------------------
    // N = 8 instance
    // ---------------------------------------------------------------------
    logic         in_valid8  = 1'b0;
    logic         in_ready8;
    logic [7:0]   a8         = '0;
    logic [7:0]   b8         = '0;
    logic [3:0]   h8         = '0;
    logic [4:0]   v8         = '0;
    logic         out_valid8;
    logic         out_ready8 = 1'b0;
    logic [15:0]  result8;
    logic         busy8;
    logic [1:0]   dbg8;

    bam_seq_mult #(.N(8)) dut8 (
        .clk       (clk),
        .rst       (rst8),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .a         (a8),
        .b         (b8),
        .cfg_h     (h8),
        .cfg_v     (v8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .result    (result8),
        .busy      (busy8),
        .dbg_state (dbg8)
    );

    // ---------------------------------------------------------------------
    // N = 12 instance
    // ---------------------------------------------------------------------
    logic         in_valid12  = 1'b0;
    logic         in_ready12;
    logic [11:0]  a12         = '0;
    logic [11:0]  b12         = '0;
    logic [3:0]   h12         = '0;
    logic [4:0]   v12         = '0;
    logic         out_valid12;
    logic         out_ready12 = 1'b0;
    logic [23:0]  result12;
    logic         busy12;
    logic [1:0]   dbg12;

    bam_seq_mult #(.N(12)) dut12 (
        .clk       (clk),
        .rst       (rst12),
        .in_valid  (in_valid12),
        .in_ready  (in_ready12),
        .a         (a12),
        .b         (b12),
        .cfg_h     (h12),
        .cfg_v     (v12),
        .out_valid (out_valid12),
        .out_ready (out_ready12),
        .result    (result12),
        .busy      (busy12),
        .dbg_state (dbg12)
    );

    // ---------------------------------------------------------------------
    // Scoreboard state
    // ---------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [15:0] exp_q8[$];
    logic [23:0] exp_q12[$];

    task automatic chk(input string name, input longint unsigned act,
                       input longint unsigned exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference: sum of retained partial products, straight from the rule.
    function automatic longint unsigned bam_ref(input int n, input longint unsigned x,
                                                input longint unsigned y,
                                                input int h, input int v);
        longint unsigned s = 0;
        for (int j = 0; j < n; j++)
            for (int i = 0; i < n; i++)
                if (j >= h && i + j >= v && x[i] && y[j])
                    s += (64'd1 << (i + j));
        return s;
    endfunction

    function automatic int exp_lat(input int n, input int h);
        return (h >= n) ? 0 : n - h;
    endfunction

    // ---------------------------------------------------------------------
    // Driver tasks: one full transaction, returns result and latency
    // (rising edges after the accepting edge until out_valid is seen).
    // ---------------------------------------------------------------------
    task automatic run8(input logic [7:0] ta, input logic [7:0] tb,
                        input logic [3:0] th, input logic [4:0] tv,
                        input int stall, output logic [15:0] res, output int lat);
        int guard;
        bit hold_ok;
        res = '0;
        lat = -1;
        @(negedge clk);
        a8 = ta; b8 = tb; h8 = th; v8 = tv; in_valid8 = 1'b1;
        guard = 0;
        while (!in_ready8 && guard < 64) begin @(negedge clk); guard++; end
        if (!in_ready8) begin chk("accept_timeout8", 0, 1); in_valid8 = 1'b0; return; end
        @(posedge clk); #1;
        // Scramble inputs while busy: latched copies must be used.
        in_valid8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); h8 = 4'($urandom); v8 = 5'($urandom);
        lat = 0;
        while (!out_valid8 && lat < 64) begin @(posedge clk); #1; lat++; end
        if (!out_valid8) begin chk("done_timeout8", 0, 1); return; end
        res = result8;
        hold_ok = 1'b1;
        for (int k = 0; k < stall; k++) begin
            @(posedge clk); #1;
            if (result8 !== res || !out_valid8 || in_ready8) hold_ok = 1'b0;
        end
        if (stall > 0) chk("hold8", 64'(hold_ok), 1);
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        out_ready8 = 1'b0;
    endtask

    task automatic run12(input logic [11:0] ta, input logic [11:0] tb,
                         input logic [3:0] th, input logic [4:0] tv,
                         input int stall, output logic [23:0] res, output int lat);
        int guard;
        bit hold_ok;
        res = '0;
        lat = -1;
        @(negedge clk);
        a12 = ta; b12 = tb; h12 = th; v12 = tv; in_valid12 = 1'b1;
        guard = 0;
        while (!in_ready12 && guard < 64) begin @(negedge clk); guard++; end
        if (!in_ready12) begin chk("accept_timeout12", 0, 1); in_valid12 = 1'b0; return; end
        @(posedge clk); #1;
        in_valid12 = 1'b0;
        a12 = 12'($urandom); b12 = 12'($urandom); h12 = 4'($urandom); v12 = 5'($urandom);
        lat = 0;
        while (!out_valid12 && lat < 64) begin @(posedge clk); #1; lat++; end
        if (!out_valid12) begin chk("done_timeout12", 0, 1); return; end
        res = result12;
        hold_ok = 1'b1;
        for (int k = 0; k < stall; k++) begin
            @(posedge clk); #1;
            if (result12 !== res || !out_valid12 || in_ready12) hold_ok = 1'b0;
        end
        if (stall > 0) chk("hold12", 64'(hold_ok), 1);
        out_ready12 = 1'b1;
        @(posedge clk); #1;
        out_ready12 = 1'b0;
    endtask

    // ---------------------------------------------------------------------
    // Directed vector table (N = 8)
    // ---------------------------------------------------------------------
    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [3:0]  h;
        logic [4:0]  v;
        logic [15:0] res;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    // Watchdog: a hung DUT must still end the run.
    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] r8;
        logic [23:0] r12;
        int lat;
        int guard;
        bit quiet;

        vecs[0]  = '{8'd255, 8'd255, 4'd0,  5'd0,  16'd65025, 8};
        vecs[1]  = '{8'd255, 8'd255, 4'd3,  5'd10, 16'd58368, 5};
        vecs[2]  = '{8'd200, 8'd100, 4'd8,  5'd0,  16'd0,     0};
        vecs[3]  = '{8'd13,  8'd11,  4'd0,  5'd0,  16'd143,   8};
        vecs[4]  = '{8'd3,   8'd5,   4'd0,  5'd0,  16'd15,    8};
        vecs[5]  = '{8'd255, 8'd255, 4'd0,  5'd15, 16'd0,     8};
        vecs[6]  = '{8'd1,   8'd128, 4'd7,  5'd0,  16'd128,   1};
        vecs[7]  = '{8'd255, 8'd1,   4'd0,  5'd8,  16'd0,     8};
        vecs[8]  = '{8'd15,  8'd15,  4'd0,  5'd0,  16'd225,   8};
        vecs[9]  = '{8'd255, 8'd255, 4'd0,  5'd14, 16'd16384, 8};
        vecs[10] = '{8'd200, 8'd100, 4'd15, 5'd0,  16'd0,     0};
        vecs[11] = '{8'd128, 8'd255, 4'd0,  5'd0,  16'd32640, 8};

        // ---- reset state ----
        rst8 = 1'b1; rst12 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready8",   64'(in_ready8),  1);
        chk("rst_out_valid8",  64'(out_valid8), 0);
        chk("rst_busy8",       64'(busy8),      0);
        chk("rst_result8",     64'(result8),    0);
        chk("rst_in_ready12",  64'(in_ready12), 1);
        chk("rst_result12",    64'(result12),   0);
        @(negedge clk);
        rst8 = 1'b0; rst12 = 1'b0;

        // ---- table vectors ----
        for (int t = 0; t < 12; t++) begin
            run8(vecs[t].a, vecs[t].b, vecs[t].h, vecs[t].v, t % 3, r8, lat);
            chk($sformatf("vec%0d_result", t), 64'(r8), 64'(vecs[t].res));
            chk($sformatf("vec%0d_latency", t), 64'(lat), 64'(vecs[t].lat));
        end

        // ---- h = N: one-cycle busy with out_ready already high ----
        @(negedge clk);
        a8 = 8'd200; b8 = 8'd100; h8 = 4'd8; v8 = 5'd0;
        in_valid8 = 1'b1; out_ready8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        chk("hN_out_valid",   64'(out_valid8), 1);
        chk("hN_in_ready_lo", 64'(in_ready8),  0);
        chk("hN_result",      64'(result8),    0);
        @(posedge clk); #1;
        chk("hN_in_ready_hi", 64'(in_ready8),  1);
        chk("hN_out_valid_lo", 64'(out_valid8), 0);
        out_ready8 = 1'b0;

        // ---- output stall with a second beat waiting ----
        @(negedge clk);
        a8 = 8'd13; b8 = 8'd11; h8 = 4'd0; v8 = 5'd0; in_valid8 = 1'b1;
        @(posedge clk); #1;
        a8 = 8'd2; b8 = 8'd3;               // second beat, held by producer
        lat = 0;
        while (!out_valid8 && lat < 64) begin @(posedge clk); #1; lat++; end
        chk("stall_latency", 64'(lat), 8);
        for (int k = 0; k < 3; k++) begin
            chk("stall_result",   64'(result8),  143);
            chk("stall_in_ready", 64'(in_ready8), 0);
            @(posedge clk); #1;
        end
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        out_ready8 = 1'b0;
        chk("post_hs_out_valid", 64'(out_valid8), 0);
        chk("post_hs_in_ready",  64'(in_ready8),  1);
        chk("post_hs_result",    64'(result8),    143);
        @(posedge clk); #1;                 // second beat accepted here
        in_valid8 = 1'b0;
        chk("beat2_busy", 64'(busy8), 1);
        lat = 0;
        while (!out_valid8 && lat < 64) begin @(posedge clk); #1; lat++; end
        chk("beat2_latency", 64'(lat), 8);
        chk("beat2_result",  64'(result8), 6);
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        out_ready8 = 1'b0;

        // ---- asynchronous reset in the middle of CALC ----
        @(negedge clk);
        a8 = 8'd255; b8 = 8'd255; h8 = 4'd0; v8 = 5'd0; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("midcalc_state", 64'(dbg8), 1);
        #2;
        rst8 = 1'b1;
        #1;
        chk("arst_out_valid", 64'(out_valid8), 0);
        chk("arst_result",    64'(result8),    0);
        chk("arst_in_ready",  64'(in_ready8),  1);
        @(negedge clk);
        rst8 = 1'b0;
        quiet = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (out_valid8) quiet = 1'b0;
        end
        chk("arst_no_stale_result", 64'(quiet), 1);
        run8(8'd3, 8'd5, 4'd0, 5'd0, 0, r8, lat);
        chk("arst_next_result",  64'(r8),  15);
        chk("arst_next_latency", 64'(lat), 8);

        // ---- random sweep, N = 8 ----
        for (int t = 0; t < 150; t++) begin
            logic [7:0] ra, rb;
            logic [3:0] rh;
            logic [4:0] rv;
            int st;
            ra = 8'($urandom);
            rb = 8'($urandom);
            rh = 4'($urandom_range(10, 0));
            rv = 5'($urandom_range(18, 0));
            st = ($urandom_range(1, 0) == 1) ? int'($urandom_range(4, 1)) : 0;
            exp_q8.push_back(16'(bam_ref(8, 64'(ra), 64'(rb), int'(rh), int'(rv))));
            run8(ra, rb, rh, rv, st, r8, lat);
            chk("rand8_result",  64'(r8),  64'(exp_q8.pop_front()));
            chk("rand8_latency", 64'(lat), 64'(exp_lat(8, int'(rh))));
        end

        // ---- random sweep, N = 12 ----
        for (int t = 0; t < 100; t++) begin
            logic [11:0] ra, rb;
            logic [3:0] rh;
            logic [4:0] rv;
            int st;
            ra = 12'($urandom);
            rb = 12'($urandom);
            rh = 4'($urandom_range(14, 0));
            rv = 5'($urandom_range(26, 0));
            st = ($urandom_range(1, 0) == 1) ? int'($urandom_range(4, 1)) : 0;
            exp_q12.push_back(24'(bam_ref(12, 64'(ra), 64'(rb), int'(rh), int'(rv))));
            run12(ra, rb, rh, rv, st, r12, lat);
            chk("rand12_result",  64'(r12), 64'(exp_q12.pop_front()));
            chk("rand12_latency", 64'(lat), 64'(exp_lat(12, int'(rh))));
        end

        // Exact-product corner at full width, N = 12.
        run12(12'hFFF, 12'hFFF, 4'd0, 5'd0, 0, r12, lat);
        chk("n12_max_exact", 64'(r12), 64'(24'hFFE001));

        guard = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bam_seq_mult.md
Name: bam_seq_mult

Overview:
- Parametrised, iterative unsigned broken-array multiplier (BAM) with run-time approximation control.
- Computes the sum of the retained partial products of a × b. Partial product a[i]&b[j] at weight i+j is retained iff j ≥ h (horizontal break) and i+j ≥ v (vertical break).
- Processes one partial-product row per clock and skips broken rows, so a higher h gives a shorter latency.
- Sits in the approximate-arithmetic library beside the combinational BAM generators. It serves as a low-area, reconfigurable multiplier with valid/ready streaming handshakes on both sides.

Parameters:
- N, 8, operand width in bits (N ≥ 2); result is 2N bits.
- HW, $clog2(N+1), width of the cfg_h field.
- VW, $clog2(2*N+1), width of the cfg_v field.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand/config beat valid.
- in_ready  output  1  block can accept a beat.
- a  input  N  multiplicand (unsigned).
- b  input  N  multiplier (unsigned).
- cfg_h  input  HW  horizontal break: rows j < cfg_h omitted.
- cfg_v  input  VW  vertical break: weights i+j < cfg_v omitted.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  2N  approximate product.
- busy  output  1  high in CALC or DONE.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset (async assert, any state): state = IDLE, result = 0, out_valid = 0, in_ready = 1, busy = 0, internal registers = 0.
- Reset applies immediately, including mid-CALC or in DONE. Any in-flight result is discarded and never presented.
- FSM states: IDLE, CALC, DONE.
- in_ready = (state == IDLE); out_valid = (state == DONE); busy = !in_ready.
- IDLE: on in_valid && in_ready:
  - latch a, b, cfg_h, cfg_v; clear accumulator; row counter = cfg_h.
  - If cfg_h ≥ N, go to DONE with result 0. Otherwise go to CALC.
- CALC, each cycle at row j:
  - acc += ((a & M_j) << j), where M_j[i] = b[j] && (i + j ≥ v).
  - Addition is full 2N-bit. No truncation and no dropped carries; bit 2N−1 is retained.
  - If j == N−1, go to DONE and load result = final acc. Otherwise increment j.
- Latency: out_valid is asserted after exactly max(N − h, 0) rising edges following the accepting edge. When h ≥ N, out_valid is visible in the cycle right after acceptance.
- cfg_v ≥ 2N−1 with cfg_v > max weight: all bits masked, result = 0, but CALC still runs N − h cycles (no early exit on v).
- cfg_v = 0 and cfg_h = 0: exact product a*b.
- DONE:
  - result is held stable and out_valid stays high until out_ready is sampled high.
  - On out_valid && out_ready, go to IDLE. result keeps its last value (out_valid = 0).
- Back-to-back: new beat acceptable the cycle after the output handshake (in_ready high in IDLE). No overlap; at most one operation in flight.
- Inputs a/b/cfg changing while busy: ignored (latched copies used).
- in_valid while busy: not accepted; the producer must hold the beat.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

Test Plan:
- N=8, a=255, b=255, h=0, v=0 → result 65025 (0xFE01); out_valid 8 edges after accept.
- N=8, a=255, b=255, h=3, v=10 → result 58368 (0xE400, bit 15 set); out_valid 5 edges after accept.
- N=8, a=200, b=100, h=8, v=0 → result 0; out_valid the cycle after accept; in_ready low for exactly that cycle if out_ready=1.
- N=8, a=13, b=11, h=0, v=0:
  - hold out_ready=0 for 3 cycles after out_valid → result stays 143 and in_ready stays 0.
  - A second beat (a=2, b=3) offered meanwhile is accepted only after the handshake and yields 6.
- Assert rst during CALC (row 4) of a=255, b=255 → outputs immediately out_valid=0, result=0, in_ready=1. The next beat a=3, b=5, h=0, v=0 → 15.
- Random sweep (N=8 and N=12, random a, b, h, v, random out_ready stalls) → result equals the reference-model sum of retained partial products; latency equals max(N−h, 0).
